// File: rtl/dot_matrix_scanner.sv
// dot_matrix_scanner: drives an 8x8 LED dot matrix one row per scan period.
// The scan clock is edge-detected on the system clock. The requested frame is
// latched only when the scan wraps from row 7 to row 0, so a frame never
// tears. All rows are held off for BLANK_CYCLES after each row change to
// suppress ghosting.
module dot_matrix_scanner #(
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1kHz,
    input  logic [1:0] mode,
    input  logic [2:0] pattern,
    output logic [7:0] row_n,
    output logic [7:0] col,
    output logic [2:0] cur_row,
    output logic       frame_done
);

    localparam logic [15:0] BLANK_LOAD = 16'(BLANK_CYCLES);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Walk animation. Each frame is packed with row 0 in the most significant byte.
    function automatic logic [63:0] walk_art(input logic [2:0] p);
        logic [63:0] a;
        case (p)
            3'd0:    a = 64'h18_18_3C_5A_18_24_42_42;
            3'd1:    a = 64'h18_18_3C_5A_18_28_48_4C;
            3'd2:    a = 64'h18_18_3C_5A_18_18_28_2C;
            3'd3:    a = 64'h18_18_1C_3A_18_14_12_32;
            3'd4:    a = 64'h18_18_3C_5A_18_24_42_81;
            3'd5:    a = 64'h18_18_3C_5A_18_14_12_16;
            3'd6:    a = 64'h18_18_38_5C_18_18_14_34;
            3'd7:    a = 64'h18_18_3C_5A_18_28_24_64;
            default: a = 64'h0;
        endcase
        return a;
    endfunction

    // Run animation, same packing as the walk frames.
    function automatic logic [63:0] run_art(input logic [2:0] p);
        logic [63:0] a;
        case (p)
            3'd0:    a = 64'h0C_0C_3E_4C_1C_36_62_03;
            3'd1:    a = 64'h0C_0C_1E_2C_1C_14_24_06;
            3'd2:    a = 64'h0C_0C_7C_0E_0C_1C_34_24;
            3'd3:    a = 64'h0C_0C_3C_5E_0C_3C_46_40;
            3'd4:    a = 64'h0C_0C_1F_2C_1C_66_43_01;
            3'd5:    a = 64'h0C_0C_3E_4C_0C_1C_24_2C;
            3'd6:    a = 64'h0C_0C_1C_2E_4C_1E_32_20;
            3'd7:    a = 64'h0C_0C_3E_5C_0C_34_26_60;
            default: a = 64'h0;
        endcase
        return a;
    endfunction

    // Frame ROM lookup: one row of column data for a latched mode/pattern.
    function automatic logic [7:0] frame_row(input logic [1:0] m,
                                             input logic [2:0] p,
                                             input logic [2:0] r);
        logic [63:0] art;
        logic [5:0]  sh;
        case (m)
            2'd0:    art = walk_art(p);
            2'd1:    art = run_art(p);
            2'd2:    art = 64'h18_18_3C_5A_18_24_24_66;
            default: art = 64'h0;
        endcase
        sh = {3'd7 - r, 3'b000};
        return 8'(art >> sh);
    endfunction

    logic       clk_1kHz_d_q, clk_1kHz_d_d;
    logic [2:0] row_idx_q, row_idx_d;
    logic [1:0] f_mode_q, f_mode_d;
    logic [2:0] f_pat_q, f_pat_d;
    logic [15:0] blank_cnt_q, blank_cnt_d;
    state_t     state_q, state_d;
    logic [7:0] row_n_q, row_n_d;
    logic [7:0] col_q, col_d;
    logic       frame_done_q, frame_done_d;
    logic       scan_tick;

    // Next-state logic: edge detect, row counter, frame latch and blanking FSM.
    always_comb begin
        scan_tick    = clk_1kHz & ~clk_1kHz_d_q;
        clk_1kHz_d_d = clk_1kHz;
        row_idx_d    = row_idx_q;
        f_mode_d     = f_mode_q;
        f_pat_d      = f_pat_q;
        blank_cnt_d  = blank_cnt_q;
        state_d      = state_q;
        row_n_d      = row_n_q;
        col_d        = col_q;
        frame_done_d = 1'b0;

        if (scan_tick) begin
            // A tick always wins, even in the middle of a blanking interval.
            row_idx_d   = row_idx_q + 3'd1;
            blank_cnt_d = BLANK_LOAD;
            if (row_idx_q == 3'd7) begin
                f_mode_d     = mode;
                f_pat_d      = pattern;
                frame_done_d = 1'b1;
            end else begin
                frame_done_d = 1'b0;
            end
            if (BLANK_LOAD == 16'd0) begin
                // No blanking: drive the new row with the frame in effect after this edge.
                state_d = ST_DRIVE;
                row_n_d = ~(8'd1 << row_idx_d);
                col_d   = frame_row(f_mode_d, f_pat_d, row_idx_d);
            end else begin
                state_d = ST_BLANK;
                row_n_d = 8'hFF;
                col_d   = 8'h00;
            end
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (blank_cnt_q > 16'd1) begin
                        blank_cnt_d = blank_cnt_q - 16'd1;
                    end else begin
                        blank_cnt_d = 16'd0;
                        state_d     = ST_DRIVE;
                        row_n_d     = ~(8'd1 << row_idx_q);
                        col_d       = frame_row(f_mode_q, f_pat_q, row_idx_q);
                    end
                end
                ST_DRIVE: begin
                    state_d = ST_DRIVE;
                end
                default: begin
                    state_d = ST_DRIVE;
                    row_n_d = 8'hFF;
                    col_d   = 8'h00;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_1kHz_d_q <= 1'b0;
            row_idx_q    <= 3'd7;
            f_mode_q     <= 2'd2;
            f_pat_q      <= 3'd0;
            blank_cnt_q  <= 16'd0;
            state_q      <= ST_DRIVE;
            row_n_q      <= 8'hFF;
            col_q        <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            clk_1kHz_d_q <= clk_1kHz_d_d;
            row_idx_q    <= row_idx_d;
            f_mode_q     <= f_mode_d;
            f_pat_q      <= f_pat_d;
            blank_cnt_q  <= blank_cnt_d;
            state_q      <= state_d;
            row_n_q      <= row_n_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign row_n      = row_n_q;
    assign col        = col_q;
    assign cur_row    = row_idx_q;
    assign frame_done = frame_done_q;

endmodule
